// File: rtl/id_ex_pkg.sv
// Shared types and constants for the ID/EX pipeline register slice.
package id_ex_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_EX_W  = 3;
  localparam int unsigned DEF_M_W   = 3;
  localparam int unsigned DEF_WB_W  = 2;

  localparam int unsigned RD_LSB   = 7;
  localparam int unsigned RS1_LSB  = 15;
  localparam int unsigned RS2_LSB  = 20;
  localparam int unsigned REGIDX_W = 5;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

  typedef struct packed {
    logic [DEF_EX_W-1:0]  ex;
    logic [DEF_M_W-1:0]   m;
    logic [DEF_WB_W-1:0]  wb;
    logic [DEF_WIDTH-1:0] pc_addr;
    logic [DEF_WIDTH-1:0] reg1;
    logic [DEF_WIDTH-1:0] reg2;
    logic [DEF_WIDTH-1:0] immediate;
    logic [DEF_WIDTH-1:0] instruction;
  } id_ex_bundle_t;

endpackage

// File: rtl/id_ex_skid_ctrl.sv
// Skid-buffer occupancy FSM: registered in_ready/out_valid plus load/promote strobes.
// Optional ID_EX_PERF_CNT_EN adds stall/bubble counters.
module id_ex_skid_ctrl
  import id_ex_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  input  logic        out_ready,
  output logic        in_ready,
  output logic        out_valid,
  output logic        load_main,
  output logic        load_skid,
  output logic        promote
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] bubble_cnt
`endif
);

  skid_state_t state, state_d;
  logic        accept, consume;

  always_comb begin
    accept    = in_valid & in_ready & ~flush;
    consume   = out_valid & out_ready;
    state_d   = state;
    load_main = 1'b0;
    load_skid = 1'b0;
    promote   = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state)
        EMPTY: if (accept) begin
          state_d   = ONE;
          load_main = 1'b1;
        end
        ONE: begin
          if (accept && consume) begin
            load_main = 1'b1;
          end else if (accept) begin
            state_d   = FULL;
            load_skid = 1'b1;
          end else if (consume) begin
            state_d = EMPTY;
          end
        end
        FULL: if (consume) begin
          state_d = ONE;
          promote = 1'b1;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Handshake outputs are registered copies of the next-state decode.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_d;
      in_ready  <= (state_d != FULL);
      out_valid <= (state_d != EMPTY);
    end
  end

`ifdef ID_EX_PERF_CNT_EN
  logic squash;

  // A flush only drops work if something stays unconsumed this cycle.
  always_comb begin
    squash = flush & ((state == FULL) | ((state == ONE) & ~consume));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (in_valid && !in_ready) stall_cnt <= stall_cnt + 32'd1;
      if (!out_valid || squash)  bubble_cnt <= bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with 2-entry skid buffer, flush and register-index extraction.
// Define ID_EX_PERF_CNT_EN to add stall_cnt/bubble_cnt performance counters.
module id_ex_pipe_reg
  import id_ex_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned EX_W  = DEF_EX_W,
  parameter int unsigned M_W   = DEF_M_W,
  parameter int unsigned WB_W  = DEF_WB_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [EX_W-1:0]     ex,
  input  logic [M_W-1:0]      m,
  input  logic [WB_W-1:0]     wb,
  input  logic [WIDTH-1:0]    pc_addr,
  input  logic [WIDTH-1:0]    reg1,
  input  logic [WIDTH-1:0]    reg2,
  input  logic [WIDTH-1:0]    immediate,
  input  logic [WIDTH-1:0]    instruction,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                alu_src_out,
  output logic [EX_W-2:0]     alu_op_out,
  output logic [M_W-1:0]      m_out,
  output logic [WB_W-1:0]     wb_out,
  output logic [WIDTH-1:0]    pc_addr_out,
  output logic [WIDTH-1:0]    reg1_out,
  output logic [WIDTH-1:0]    reg2_out,
  output logic [WIDTH-1:0]    immediate_out,
  output logic [WIDTH-1:0]    instruction_out,
  output logic [REGIDX_W-1:0] rd_out,
  output logic [REGIDX_W-1:0] rs1_out,
  output logic [REGIDX_W-1:0] rs2_out
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [31:0]         stall_cnt,
  output logic [31:0]         bubble_cnt
`endif
);

  if (EX_W < 2) begin : g_ex_w_check
    $error("id_ex_pipe_reg: EX_W must be >= 2");
  end

  localparam int unsigned BW = EX_W + M_W + WB_W + 5 * WIDTH;

  logic              load_main, load_skid, promote;
  logic [BW-1:0]     in_bundle, main_q, skid_q;
  logic [EX_W-1:0]   main_ex;
  logic [M_W-1:0]    main_m;
  logic [WB_W-1:0]   main_wb;
  logic [WIDTH-1:0]  main_instr;

  id_ex_skid_ctrl u_ctrl (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .out_ready  (out_ready),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .load_main  (load_main),
    .load_skid  (load_skid),
    .promote    (promote)
`ifdef ID_EX_PERF_CNT_EN
    ,
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
`endif
  );

  assign in_bundle = {ex, m, wb, pc_addr, reg1, reg2, immediate, instruction};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main)    main_q <= in_bundle;
      else if (promote) main_q <= skid_q;
      if (load_skid)    skid_q <= in_bundle;
    end
  end

  assign {main_ex, main_m, main_wb, pc_addr_out, reg1_out, reg2_out,
          immediate_out, main_instr} = main_q;

  // Controls become a bubble when nothing is valid; data just holds.
  assign alu_src_out     = out_valid & main_ex[EX_W-1];
  assign alu_op_out      = out_valid ? main_ex[EX_W-2:0] : '0;
  assign m_out           = out_valid ? main_m : '0;
  assign wb_out          = out_valid ? main_wb : '0;
  assign instruction_out = main_instr;
  assign rd_out          = main_instr[RD_LSB +: REGIDX_W];
  assign rs1_out         = main_instr[RS1_LSB +: REGIDX_W];
  assign rs2_out         = main_instr[RS2_LSB +: REGIDX_W];

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed self-checking bench for id_ex_pipe_reg (counter checks when ID_EX_PERF_CNT_EN is defined).
module tb_id_ex_pipe_reg;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic        in_ready, out_valid, alu_src_out;
  logic [2:0]  ex, m, m_out;
  logic [1:0]  wb, wb_out, alu_op_out;
  logic [31:0] pc_addr, reg1, reg2, immediate, instruction;
  logic [31:0] pc_addr_out, reg1_out, reg2_out, immediate_out, instruction_out;
  logic [4:0]  rd_out, rs1_out, rs2_out;
`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] stall_cnt, bubble_cnt, s0, b0;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  id_ex_pipe_reg #(.WIDTH(32), .EX_W(3), .M_W(3), .WB_W(2)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .ex(ex), .m(m), .wb(wb), .pc_addr(pc_addr), .reg1(reg1), .reg2(reg2),
    .immediate(immediate), .instruction(instruction), .out_valid(out_valid),
    .out_ready(out_ready), .alu_src_out(alu_src_out), .alu_op_out(alu_op_out),
    .m_out(m_out), .wb_out(wb_out), .pc_addr_out(pc_addr_out), .reg1_out(reg1_out),
    .reg2_out(reg2_out), .immediate_out(immediate_out), .instruction_out(instruction_out),
    .rd_out(rd_out), .rs1_out(rs1_out), .rs2_out(rs2_out)
`ifdef ID_EX_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic v, input logic [31:0] pc);
    in_valid    = v;
    ex          = 3'b010;
    m           = 3'b001;
    wb          = 2'b10;
    pc_addr     = pc;
    reg1        = pc + 32'd1;
    reg2        = pc + 32'd2;
    immediate   = pc + 32'd3;
    instruction = 32'h0041_8133;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".out_valid"}, out_valid, 0);
    check({tag, ".in_ready"},  in_ready, 1);
    check({tag, ".ctrl"},      {alu_src_out, alu_op_out, m_out, wb_out}, 0);
  endtask

  task automatic check_cleared(input string tag);
    check_idle(tag);
    check({tag, ".pc"},    pc_addr_out, 0);
    check({tag, ".instr"}, instruction_out, 0);
    check({tag, ".regs"},  {reg1_out, reg2_out, immediate_out}, 0);
    check({tag, ".idx"},   {rd_out, rs1_out, rs2_out}, 0);
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; out_ready = 1'b0;
    put(1'b0, 32'h0);

    // 1: reset held three cycles, then released mid-cycle
    for (int i = 0; i < 3; i++) begin
      tick();
      check_cleared("rst");
    end
`ifdef ID_EX_PERF_CNT_EN
    check("rst.stall_cnt", stall_cnt, 0);
    check("rst.bubble_cnt", bubble_cnt, 0);
`endif
    #2 reset = 1'b1;
    tick();
    check_cleared("post_rst");

    // 2: single transfer
    out_ready = 1'b1;
    in_valid = 1'b1; ex = 3'b101; m = 3'b111; wb = 2'b11;
    pc_addr = 32'h1; reg1 = 32'h2; reg2 = 32'h3; immediate = 32'h4;
    instruction = 32'h00A3_02B3;
    tick();
    check("t2.out_valid", out_valid, 1);
    check("t2.alu_src", alu_src_out, 1);
    check("t2.alu_op", alu_op_out, 2'b01);
    check("t2.m", m_out, 7);
    check("t2.wb", wb_out, 3);
    check("t2.data", {pc_addr_out, reg1_out, reg2_out, immediate_out}, {32'h1, 32'h2, 32'h3, 32'h4});
    check("t2.instr", instruction_out, 32'h00A3_02B3);
    check("t2.rd", rd_out, 5);
    check("t2.rs1", rs1_out, 6);
    check("t2.rs2", rs2_out, 10);
    in_valid = 1'b0;
    tick();
    check("t2.valid_drop", out_valid, 0);
    check("t2.bubble_ctrl", {alu_src_out, alu_op_out, m_out, wb_out}, 0);
    check("t2.pc_hold", pc_addr_out, 32'h1);
    check("t2.rd_hold", rd_out, 5);

    // 3: back-pressure, skid fill and in-order drain
    out_ready = 1'b0;
    put(1'b1, 32'h10);
    tick();
    check("t3.a1_ready", in_ready, 1);
    check("t3.a1_pc", pc_addr_out, 32'h10);
    check("t3.a1_op", alu_op_out, 2'b10);
    put(1'b1, 32'h14);
    tick();
    check("t3.full_ready", in_ready, 0);
    check("t3.full_pc", pc_addr_out, 32'h10);
    put(1'b1, 32'h18);
    tick();
    check("t3.hold_ready", in_ready, 0);
    check("t3.hold_pc", pc_addr_out, 32'h10);
    out_ready = 1'b1;
    #1 check("t3.d0_pc", pc_addr_out, 32'h10);
    tick();
    check("t3.d1_pc", pc_addr_out, 32'h14);
    check("t3.d1_r1", reg1_out, 32'h15);
    check("t3.d1_ready", in_ready, 1);
    tick();
    check("t3.d2_pc", pc_addr_out, 32'h18);
    check("t3.d2_valid", out_valid, 1);
    put(1'b0, 32'h0);
    tick();
    check("t3.drained", out_valid, 0);

    // 4: flush while full, colliding with a new bundle
    out_ready = 1'b0;
    put(1'b1, 32'h30);
    tick();
    put(1'b1, 32'h34);
    tick();
    check("t4.full", in_ready, 0);
    flush = 1'b1;
    put(1'b1, 32'h20);
    tick();
    check_idle("t4.flush");
    check("t4.pc_not_20", pc_addr_out, 32'h30);
    flush = 1'b0;
    put(1'b0, 32'h0);
    tick();
    check("t4.after_valid", out_valid, 0);
    check("t4.after_pc", pc_addr_out, 32'h30);

    // 5: asynchronous reset mid-cycle while full
    put(1'b1, 32'h50);
    tick();
    put(1'b1, 32'h54);
    tick();
    check("t5.full", in_ready, 0);
    #3 reset = 1'b0;
    #1 check_cleared("t5.async");
    tick();
    #2 reset = 1'b1;
    out_ready = 1'b1;
    put(1'b1, 32'h40);
    tick();
    check("t5.new_valid", out_valid, 1);
    check("t5.new_pc", pc_addr_out, 32'h40);
    put(1'b0, 32'h0);
    tick();
    check("t5.new_done", out_valid, 0);

`ifdef ID_EX_PERF_CNT_EN
    // 6: performance counters
    out_ready = 1'b0;
    put(1'b1, 32'h60);
    tick();
    put(1'b1, 32'h64);
    tick();
    s0 = stall_cnt;
    for (int i = 0; i < 10; i++) tick();
    check("t6.stall_delta", stall_cnt - s0, 10);
    b0 = bubble_cnt;
    flush = 1'b1;
    put(1'b0, 32'h0);
    tick();
    check("t6.bubble_flush", bubble_cnt - b0, 1);
    flush = 1'b0;
    tick();
    tick();
    check("t6.bubble_empty", bubble_cnt - b0, 3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
Parametrised ID/EX pipeline register with a valid/ready handshake, a 2-entry skid buffer, synchronous flush (bubble insertion), and register-index extraction. It sits between decode/register-read and execute. Execute can back-pressure decode without combinational ready paths, and control hazards squash in-flight instructions. Control-field widths are parameters so wider EX/M/WB bundles reuse the block.

Parameters:
WIDTH, 32, datapath width of pc/reg/imm/instruction fields
EX_W, 3, EX control width; MSB is ALUSrc, low EX_W-1 bits are ALUOp
M_W, 3, memory-stage control width
WB_W, 2, writeback control width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
flush  in  1  synchronous squash of all held and incoming entries
in_valid  in  1  decode presents a valid bundle
in_ready  out  1  block can accept a bundle this cycle (registered)
ex  in  EX_W  EX controls
m  in  M_W  M controls
wb  in  WB_W  WB controls
pc_addr, reg1, reg2, immediate, instruction  in  WIDTH each  decode data
out_valid  out  1  output bundle valid
out_ready  in  1  execute consumes the bundle this cycle
alu_src_out  out  1  EX[EX_W-1] of head entry
alu_op_out  out  EX_W-1  EX[EX_W-2:0] of head entry
m_out  out  M_W  head M controls
wb_out  out  WB_W  head WB controls
pc_addr_out, reg1_out, reg2_out, immediate_out, instruction_out  out  WIDTH each  head data
rd_out, rs1_out, rs2_out  out  5 each  instruction[11:7], [19:15], [24:20] of head

Behaviour:
- Storage: main entry (drives outputs) plus skid entry. State EMPTY / ONE / FULL.
- Accept = in_valid & in_ready & !flush. Consume = out_valid & out_ready.
- EMPTY: accept -> ONE (main loaded).
- ONE:
  - accept & consume -> ONE (main reloaded).
  - accept & !consume -> FULL (skid loaded).
  - consume & !accept -> EMPTY.
- FULL: consume -> ONE (skid promoted to main, same edge). No accept is possible.
- in_ready is registered and equals (next state != FULL). It is 1 after reset.
- out_valid = (state != EMPTY).
- Latency: an accepted bundle appears at the outputs the next cycle. Throughput is 1/cycle while out_ready = 1.
- Ordering is strict FIFO. Nothing is dropped or duplicated without flush.
- Bubble rule: while out_valid = 0, alu_src_out, alu_op_out, m_out and wb_out are forced to 0. Data outputs and rd/rs fields hold their last value.
- Flush:
  - Highest priority. Next state is EMPTY and both entries are invalidated.
  - A same-cycle in_valid bundle is discarded.
  - A same-cycle consume still counts; execute saw the bundle.
  - in_ready is 1 in the following cycle.
- Reset (asserted at any time, including mid-transfer):
  - State EMPTY; all outputs 0 except in_ready = 1.
  - Entries cleared to 0.
  - First accept is possible on the first rising edge after deassertion.
- Widths: ALUOp width is EX_W-1. EX_W must be >= 2; a static assertion rejects smaller values.

Optional Feature:
ID_EX_PERF_CNT_EN
- Defined: adds outputs stall_cnt [31:0] and bubble_cnt [31:0], both reset to 0.
  - stall_cnt increments each cycle with in_valid & !in_ready.
  - bubble_cnt increments each cycle with !out_valid, plus once per flush that invalidates at least one held entry.
  - Both counters wrap at 2^32 (0xFFFFFFFF -> 0).
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package id_ex_pkg:
  - typedef struct packed id_ex_bundle_t (ex, m, wb, pc_addr, reg1, reg2, immediate, instruction), using parameter defaults.
  - enum skid_state_t {EMPTY, ONE, FULL}.
  - Constants RD_LSB=7, RS1_LSB=15, RS2_LSB=20, REGIDX_W=5.
- One sub-module, id_ex_skid_ctrl: the state machine plus in_ready/out_valid/load/promote strobes. The top holds the storage and the output muxing.

Test Plan:
1. Reset low for 3 cycles, then release. Expect all outputs 0, in_ready = 1 and out_valid = 0 throughout. One cycle after release, check the same again.
2. Single transfer with out_ready = 1. Drive ex=3'b101, m=3'b111, wb=2'b11, pc=0x1, reg1=0x2, reg2=0x3, imm=0x4, instr=0x00A302B3 for one cycle. Next cycle expect:
   - alu_src_out = 1, alu_op_out = 2'b01, m_out = 7, wb_out = 3;
   - rd_out = 5, rs1_out = 6, rs2_out = 10;
   - out_valid for exactly 1 cycle.
3. Back-pressure with out_ready = 0. Stream pc = 0x10, 0x14, 0x18. Expect in_ready to drop after the second accept and 0x18 to be held by decode. Then raise out_ready. Expect outputs 0x10, 0x14, 0x18 on consecutive cycles with no loss.
4. Flush while FULL, with in_valid = 1 (pc = 0x20) in the same cycle. Next cycle expect out_valid = 0, control outputs 0 and in_ready = 1. pc 0x20 must never appear at the outputs.
5. Reset asserted asynchronously mid-cycle while FULL. Outputs clear immediately, before the next edge. After release, a new bundle pc = 0x40 passes with 1-cycle latency.
6. With ID_EX_PERF_CNT_EN: hold in_valid = 1 and out_ready = 0 for 10 cycles after the FULL state is reached. Expect stall_cnt = 10. Then flush once with both entries held. Expect bubble_cnt to increment by 1 for the flush plus 1 per following empty cycle.
